// File: rtl/interrupt_sequencer_if.sv
// Handshake bundle between the main control logic and the interrupt
// sequencer: request/qualifier inputs and per-cycle dataflow strobes.
interface interrupt_sequencer_if;
   logic       rdy;
   logic       instr_boundary;
   logic       reset_req;
   logic       nmi;
   logic       irq;
   logic       brk;
   logic       i_flag;
   logic       busy;
   logic [2:0] cycle;
   logic [1:0] kind;
   logic       pc_inc;
   logic       push_we;
   logic [1:0] push_src;
   logic       b_flag;
   logic       sp_dec;
   logic [7:0] vec_adl;
   logic [7:0] vec_adh;
   logic       set_i;
   logic       done;

   modport master (
      output rdy, instr_boundary, reset_req, nmi, irq, brk, i_flag,
      input  busy, cycle, kind, pc_inc, push_we, push_src, b_flag,
             sp_dec, vec_adl, vec_adh, set_i, done
   );

   modport slave (
      input  rdy, instr_boundary, reset_req, nmi, irq, brk, i_flag,
      output busy, cycle, kind, pc_inc, push_we, push_src, b_flag,
             sp_dec, vec_adl, vec_adh, set_i, done
   );
endinterface

// File: rtl/interrupt_sequencer.sv
// Interrupt sequencer: arbitrates RESET/NMI/BRK/IRQ at instruction
// boundaries and steps the fixed 7-cycle service routine (2 dummy cycles,
// PCH/PCL/PSR pushes, 2 vector fetches).
// Optional build macro NMI_HIJACK_EN: a pending NMI taken over an IRQ/BRK
// sequence at the cycle 5->6 transition (vector switches to the NMI one).
module interrupt_sequencer #(
   parameter logic [7:0] VEC_PAGE = 8'hFF
) (
   input  logic                  clk,
   input  logic                  rst,
   interrupt_sequencer_if.slave  bus
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      CYC1 = 3'd1,
      CYC2 = 3'd2,
      CYC3 = 3'd3,
      CYC4 = 3'd4,
      CYC5 = 3'd5,
      CYC6 = 3'd6,
      CYC7 = 3'd7
   } stateT;

   typedef enum logic [1:0] {
      KIND_RESET = 2'd0,
      KIND_NMI   = 2'd1,
      KIND_IRQ   = 2'd2,
      KIND_BRK   = 2'd3
   } kindT;

   stateT state, stateNext;
   kindT  kindQ, kindNext, winner;
   logic  resetPending, nmiPending, nmiPrev;
   logic  nmiEdge, anyReq, accept, hijack, clrReset, clrNmi;
   logic [7:0] lowVec;

   assign nmiEdge = bus.nmi & ~nmiPrev;

   // Sequencer state and latched kind; rst aborts straight to idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         kindQ <= KIND_RESET;
      end else begin
         state <= stateNext;
         kindQ <= kindNext;
      end
   end

   // Request latches keep collecting while busy or frozen; a new set wins
   // over a same-cycle clear so no request is lost.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         resetPending <= 1'b1;
         nmiPending   <= 1'b0;
         nmiPrev      <= 1'b1;
      end else begin
         resetPending <= bus.reset_req | (resetPending & ~clrReset);
         nmiPending   <= nmiEdge | (nmiPending & ~clrNmi);
         nmiPrev      <= bus.nmi;
      end
   end

   // Priority arbitration, acceptance and cycle advance.
   always_comb begin
      stateNext = state;
      kindNext  = kindQ;
      accept    = 1'b0;
      hijack    = 1'b0;
      winner    = KIND_RESET;
      anyReq    = 1'b1;
      if (resetPending)                winner = KIND_RESET;
      else if (nmiPending)             winner = KIND_NMI;
      else if (bus.brk)                winner = KIND_BRK;
      else if (bus.irq & ~bus.i_flag)  winner = KIND_IRQ;
      else                             anyReq = 1'b0;

      if (bus.rdy) begin
         case (state)
            IDLE: begin
               if (bus.instr_boundary && anyReq) begin
                  accept    = 1'b1;
                  stateNext = CYC1;
                  kindNext  = winner;
               end
            end
            CYC7:    stateNext = IDLE;
            default: stateNext = stateT'(state + 3'd1);
         endcase
`ifdef NMI_HIJACK_EN
         // Switch takes effect after the PSR push so b_flag keeps the
         // original BRK value while the vector becomes the NMI one.
         if (state == CYC5 && nmiPending &&
             (kindQ == KIND_IRQ || kindQ == KIND_BRK)) begin
            hijack   = 1'b1;
            kindNext = KIND_NMI;
         end
`endif
      end

      clrReset = accept && (winner == KIND_RESET);
      clrNmi   = (accept && (winner == KIND_NMI)) || hijack;
   end

   // Per-cycle strobes decoded from cycle/kind; rdy=0 forces all to zero.
   always_comb begin
      bus.pc_inc   = 1'b0;
      bus.push_we  = 1'b0;
      bus.push_src = 2'd0;
      bus.b_flag   = 1'b0;
      bus.sp_dec   = 1'b0;
      bus.vec_adl  = 8'h00;
      bus.vec_adh  = 8'h00;
      bus.set_i    = 1'b0;
      bus.done     = 1'b0;
      case (kindQ)
         KIND_NMI:   lowVec = 8'hFA;
         KIND_RESET: lowVec = 8'hFC;
         default:    lowVec = 8'hFE;
      endcase

      if (bus.rdy) begin
         case (state)
            CYC2: bus.pc_inc = (kindQ == KIND_BRK);
            CYC3: begin
               bus.push_src = 2'd0;
               bus.sp_dec   = 1'b1;
               bus.push_we  = (kindQ != KIND_RESET);
            end
            CYC4: begin
               bus.push_src = 2'd1;
               bus.sp_dec   = 1'b1;
               bus.push_we  = (kindQ != KIND_RESET);
            end
            CYC5: begin
               bus.push_src = 2'd2;
               bus.sp_dec   = 1'b1;
               bus.push_we  = (kindQ != KIND_RESET);
               bus.b_flag   = (kindQ == KIND_BRK);
            end
            CYC6: begin
               bus.vec_adl = lowVec;
               bus.vec_adh = VEC_PAGE;
               bus.set_i   = 1'b1;
            end
            CYC7: begin
               bus.vec_adl = lowVec | 8'h01;
               bus.vec_adh = VEC_PAGE;
               bus.done    = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy  = (state != IDLE);
   assign bus.cycle = state;
   assign bus.kind  = kindQ;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Table-driven bench for interrupt_sequencer: each row gives one clock
// cycle of inputs plus the expected cycle/kind; the strobe outputs for that
// cycle are derived from the service-cycle table and queued for the monitor.
module tb_interrupt_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic finished = 1'b0;

  interrupt_sequencer_if bus ();

  interrupt_sequencer #(.VEC_PAGE(8'hFF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic [2:0] cycle;
    logic [1:0] kind;
    logic       pc_inc;
    logic       push_we;
    logic [1:0] push_src;
    logic       b_flag;
    logic       sp_dec;
    logic [7:0] vec_adl;
    logic [7:0] vec_adh;
    logic       set_i;
    logic       done;
  } outsT;

  // in = {rst, rdy, instr_boundary, reset_req, nmi, irq, brk, i_flag}
  typedef struct packed {
    logic [7:0] in;
    logic [2:0] cyc;
    logic [1:0] knd;
  } vecT;

  vecT         vecs[$];
  outsT        expQ[$];
  int unsigned rowQ[$];
  int          tests = 0;
  int          fails = 0;

  task automatic add(input logic [7:0] in, input logic [2:0] c, input logic [1:0] k);
    vecT v;
    v.in  = in;
    v.cyc = c;
    v.knd = k;
    vecs.push_back(v);
  endtask

  function automatic outsT model(input logic [2:0] c, input logic [1:0] k, input logic r);
    outsT       o;
    logic [7:0] lo;
    o = '0;
    o.busy  = (c != 3'd0);
    o.cycle = c;
    o.kind  = k;
    lo = (k == 2'd1) ? 8'hFA : (k == 2'd0) ? 8'hFC : 8'hFE;
    if (r) begin
      case (c)
        3'd2: o.pc_inc = (k == 2'd3);
        3'd3, 3'd4, 3'd5: begin
          o.sp_dec   = 1'b1;
          o.push_we  = (k != 2'd0);
          o.push_src = 2'(c - 3'd3);
          o.b_flag   = (c == 3'd5) && (k == 2'd3);
        end
        3'd6: begin
          o.vec_adl = lo;
          o.vec_adh = 8'hFF;
          o.set_i   = 1'b1;
        end
        3'd7: begin
          o.vec_adl = lo + 8'd1;
          o.vec_adh = 8'hFF;
          o.done    = 1'b1;
        end
        default: ;
      endcase
    end
    return o;
  endfunction

  function automatic outsT sample();
    return {bus.busy, bus.cycle, bus.kind, bus.pc_inc, bus.push_we,
            bus.push_src, bus.b_flag, bus.sp_dec, bus.vec_adl,
            bus.vec_adh, bus.set_i, bus.done};
  endfunction

  // Monitor: compare queued expectations mid-cycle, away from the edge.
  always @(negedge clk) begin
    outsT        act;
    outsT        exp;
    int unsigned row;
    if (expQ.size() > 0) begin
      exp = expQ.pop_front();
      row = rowQ.pop_front();
      act = sample();
      tests++;
      if (act !== exp) begin
        fails++;
        $display("FAIL row%0d: got cyc=%0d kind=%0d pcinc=%b we=%b src=%0d b=%b spdec=%b adl=%h adh=%h seti=%b done=%b busy=%b; required cyc=%0d kind=%0d pcinc=%b we=%b src=%0d b=%b spdec=%b adl=%h adh=%h seti=%b done=%b busy=%b",
                 row, act.cycle, act.kind, act.pc_inc, act.push_we, act.push_src,
                 act.b_flag, act.sp_dec, act.vec_adl, act.vec_adh, act.set_i,
                 act.done, act.busy, exp.cycle, exp.kind, exp.pc_inc, exp.push_we,
                 exp.push_src, exp.b_flag, exp.sp_dec, exp.vec_adl, exp.vec_adh,
                 exp.set_i, exp.done, exp.busy);
      end
    end
  end

  // Watchdog: the stimulus must finish well within this bound.
  initial begin
    #100000;
    if (!finished) begin
      fails++;
      $display("FAIL timeout: stimulus did not complete, %0d tests run", tests);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
  end

  initial begin
    outsT rstAct;
    // Reset held, NMI line high through reset.
    add(8'b1_1_1_0_1_0_0_1, 3'd0, 2'd0);
    add(8'b1_1_1_0_1_0_0_1, 3'd0, 2'd0);
    // Release: first sequence is RESET, no writes; held NMI never fires.
    add(8'b0_1_1_0_1_0_0_1, 3'd0, 2'd0);
    for (int unsigned c = 1; c <= 7; c++) add(8'b0_1_1_0_1_0_0_1, 3'(c), 2'd0);
    add(8'b0_1_1_0_1_0_0_1, 3'd0, 2'd0);
    add(8'b0_1_1_0_1_0_0_1, 3'd0, 2'd0);
    // BRK with I set.
    add(8'b0_1_1_0_0_0_1_1, 3'd0, 2'd0);
    for (int unsigned c = 1; c <= 7; c++) add(8'b0_1_1_0_0_0_0_1, 3'(c), 2'd3);
    // IRQ masked, then unmasked; one-cycle NMI pulse in cycle 5.
    add(8'b0_1_1_0_0_1_0_1, 3'd0, 2'd3);
    add(8'b0_1_1_0_0_1_0_1, 3'd0, 2'd3);
    add(8'b0_1_1_0_0_1_0_0, 3'd0, 2'd3);
    for (int unsigned c = 1; c <= 7; c++)
      add((c == 5) ? 8'b0_1_1_0_1_0_0_0 : 8'b0_1_1_0_0_0_0_0, 3'(c), 2'd2);
    // Pending NMI taken right after done.
    add(8'b0_1_1_0_0_0_0_0, 3'd0, 2'd2);
    for (int unsigned c = 1; c <= 7; c++) add(8'b0_1_1_0_0_0_0_0, 3'(c), 2'd1);
    add(8'b0_1_1_0_0_0_0_0, 3'd0, 2'd1);
    // No acceptance with rdy low or off-boundary.
    add(8'b0_0_1_0_0_0_1_0, 3'd0, 2'd1);
    add(8'b0_1_0_0_0_0_1_0, 3'd0, 2'd1);
    // NMI edge, then boundary with BRK: NMI wins; NMI held high afterwards.
    add(8'b0_1_0_0_1_0_0_0, 3'd0, 2'd1);
    add(8'b0_1_1_0_1_0_1_0, 3'd0, 2'd1);
    for (int unsigned c = 1; c <= 7; c++) add(8'b0_1_1_0_1_0_0_0, 3'(c), 2'd1);
    add(8'b0_1_1_0_1_0_0_0, 3'd0, 2'd1);
    add(8'b0_1_1_0_1_0_0_0, 3'd0, 2'd1);
    // BRK with NMI edge in cycle 3.
    add(8'b0_1_1_0_0_0_1_1, 3'd0, 2'd1);
    add(8'b0_1_1_0_0_0_0_1, 3'd1, 2'd3);
    add(8'b0_1_1_0_0_0_0_1, 3'd2, 2'd3);
    add(8'b0_1_1_0_1_0_0_1, 3'd3, 2'd3);
    add(8'b0_1_1_0_1_0_0_1, 3'd4, 2'd3);
    add(8'b0_1_1_0_1_0_0_1, 3'd5, 2'd3);
`ifdef NMI_HIJACK_EN
    add(8'b0_1_1_0_1_0_0_1, 3'd6, 2'd1);
    add(8'b0_1_1_0_1_0_0_1, 3'd7, 2'd1);
    add(8'b0_1_1_0_1_0_0_1, 3'd0, 2'd1);
    add(8'b0_1_1_0_1_0_0_1, 3'd0, 2'd1);
`else
    add(8'b0_1_1_0_1_0_0_1, 3'd6, 2'd3);
    add(8'b0_1_1_0_1_0_0_1, 3'd7, 2'd3);
    add(8'b0_1_1_0_1_0_0_1, 3'd0, 2'd3);
    for (int unsigned c = 1; c <= 7; c++) add(8'b0_1_1_0_1_0_0_1, 3'(c), 2'd1);
    add(8'b0_1_1_0_1_0_0_1, 3'd0, 2'd1);
`endif
    // IRQ frozen 3 cycles in cycle 4, then rst pulse in cycle 5.
    add(8'b0_1_1_0_0_1_0_0, 3'd0, 2'd1);
    for (int unsigned c = 1; c <= 3; c++) add(8'b0_1_1_0_0_0_0_0, 3'(c), 2'd2);
    for (int unsigned i = 0; i < 3; i++) add(8'b0_0_1_0_0_0_0_0, 3'd4, 2'd2);
    add(8'b0_1_1_0_0_0_0_0, 3'd4, 2'd2);
    add(8'b1_1_1_0_0_0_0_0, 3'd0, 2'd0);
    // RESET after abort; reset_req and NMI edge arrive mid-sequence.
    add(8'b0_1_1_0_0_0_0_0, 3'd0, 2'd0);
    add(8'b0_1_1_0_0_0_0_0, 3'd1, 2'd0);
    add(8'b0_1_1_0_0_0_0_0, 3'd2, 2'd0);
    add(8'b0_1_1_1_1_0_0_0, 3'd3, 2'd0);
    for (int unsigned c = 4; c <= 7; c++) add(8'b0_1_1_0_1_0_0_0, 3'(c), 2'd0);
    add(8'b0_1_1_0_1_0_0_0, 3'd0, 2'd0);
    for (int unsigned c = 1; c <= 7; c++) add(8'b0_1_1_0_1_0_0_0, 3'(c), 2'd0);
    add(8'b0_1_1_0_1_0_0_0, 3'd0, 2'd0);
    for (int unsigned c = 1; c <= 7; c++) add(8'b0_1_1_0_1_0_0_0, 3'(c), 2'd1);
    add(8'b0_1_1_0_1_0_0_0, 3'd0, 2'd1);

    bus.rdy = 1'b1; bus.instr_boundary = 1'b1; bus.reset_req = 1'b0;
    bus.nmi = 1'b1; bus.irq = 1'b0; bus.brk = 1'b0; bus.i_flag = 1'b1;

    for (int unsigned i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      if (rst === 1'b1) begin
        rstAct = sample();
        tests++;
        if (rstAct !== outsT'('0)) begin
          fails++;
          $display("FAIL row%0d reset state: cyc=%0d kind=%0d busy=%b we=%b spdec=%b adl=%h adh=%h seti=%b done=%b",
                   i, rstAct.cycle, rstAct.kind, rstAct.busy, rstAct.push_we,
                   rstAct.sp_dec, rstAct.vec_adl, rstAct.vec_adh, rstAct.set_i,
                   rstAct.done);
        end
      end
      bus.rdy            = vecs[i].in[6];
      bus.instr_boundary = vecs[i].in[5];
      bus.reset_req      = vecs[i].in[4];
      bus.nmi            = vecs[i].in[3];
      bus.irq            = vecs[i].in[2];
      bus.brk            = vecs[i].in[1];
      bus.i_flag         = vecs[i].in[0];
      expQ.push_back(model(vecs[i].cyc, vecs[i].knd, vecs[i].in[6]));
      rowQ.push_back(i);
      #1;
      rst = vecs[i].in[7];
    end
    @(negedge clk);
    #1;
    finished = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
- Arbitrates RESET, NMI, BRK and IRQ service requests at instruction boundaries.
- For the winning request, sequences the fixed 7-cycle service routine for the internal dataflow: two dummy cycles, three stack pushes (PCH, PCL, PSR), then two vector fetches.
- Outputs are per-cycle strobes and selects that the main control logic ORs into the dataflow flag vector (stack push, SP decrement, ADL vector preset, I-flag set).

Parameters:
- VEC_PAGE, 8'hFF: ADH value the control logic drives during vector fetch. Reported on vec_adh.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- rdy  in  1  1 = advance; 0 = freeze sequencer
- instr_boundary  in  1  controller is at opcode-fetch boundary
- reset_req  in  1  level soft-reset request
- nmi  in  1  NMI line, active-high, edge-sensitive
- irq  in  1  IRQ line, active-high, level-sensitive
- brk  in  1  decoder has fetched a BRK opcode (sampled at boundary)
- i_flag  in  1  PSR interrupt-disable bit
- busy  out  1  sequence in progress (cycles 1..7)
- cycle  out  3  0 = idle, 1..7 = current service cycle
- kind  out  2  0 RESET, 1 NMI, 2 IRQ, 3 BRK; latched at acceptance
- pc_inc  out  1  skip BRK signature byte
- push_we  out  1  stack write strobe
- push_src  out  2  0 PCH, 1 PCL, 2 PSR
- b_flag  out  1  B bit value for the pushed PSR
- sp_dec  out  1  decrement SP this cycle
- vec_adl  out  8  ADL preset value during vector fetch, else 8'h00
- vec_adh  out  8  VEC_PAGE during cycles 6 and 7, else 8'h00
- set_i  out  1  set PSR I flag
- done  out  1  final service cycle (cycle 7)

Behaviour:
Reset values (rst high, asynchronous):
- cycle=0, kind=0; all strobes 0; vec_adl=vec_adh=0.
- reset_pending=1, so the first sequence after reset release is always RESET.
- nmi_prev=1, so an NMI held high through reset does not fire.

Request latching:
- reset_pending is set by reset_req level.
- nmi_pending is set on a registered rising edge (nmi & ~nmi_prev).
- brk and irq are not latched.
- A pending bit is cleared when its kind is accepted. If set and clear occur in the same cycle, set wins.
- Latching continues while busy and while rdy=0.

Acceptance:
- Condition: cycle=0 & instr_boundary & rdy.
- Priority: reset_pending > nmi_pending > brk > (irq & ~i_flag).
- On acceptance, cycle becomes 1 on the next edge and kind is latched.
- Requests arriving while busy wait for the next boundary.

Per-cycle outputs (all strobes are gated by rdy; rdy=0 holds cycle and forces every strobe to 0):
- cycle 1: no strobes. (Dummy opcode re-read.)
- cycle 2: pc_inc=1 for BRK only.
- cycle 3: push_src=0; sp_dec=1; push_we=1 unless kind=RESET.
- cycle 4: push_src=1; sp_dec=1; push_we=1 unless kind=RESET.
- cycle 5: push_src=2; sp_dec=1; push_we=1 unless kind=RESET; b_flag=1 for BRK only.
- cycle 6: vec_adl = FA (NMI), FC (RESET), or FE (IRQ/BRK); set_i=1.
- cycle 7: vec_adl = low vector + 1 (FB/FD/FF); done=1; next state is cycle 0.

Additional rules:
- RESET still decrements SP three times but performs no writes.
- cycle wraps from 7 to 0 only. Values outside 0..7 are unreachable.
- A new acceptance is possible in the cycle immediately after done, if instr_boundary is high.
- rst asserted mid-sequence aborts to idle with reset_pending=1. No partial strobes are emitted after rst rises.

Optional Feature:
- Macro: NMI_HIJACK_EN.
- Defined: if nmi_pending is set during cycles 1..5 of an IRQ or BRK sequence, then at the cycle 5→6 transition:
  - kind switches to NMI; vec_adl uses FA/FB; nmi_pending clears.
  - The pushed b_flag keeps the original value (1 for BRK).
- Undefined: kind is fixed for the whole sequence; the NMI waits for the next boundary.

Test Plan:
1. Release rst, instr_boundary=1, rdy=1.
   -> kind=0, cycles 1..7; push_we never 1; sp_dec high exactly in cycles 3-5; vec_adl FC then FD; done in cycle 7.
2. Idle, brk=1 at boundary, i_flag=1.
   -> kind=3; pc_inc only in cycle 2; push_src 0,1,2 with push_we in cycles 3-5; b_flag=1 in cycle 5; vec_adl FE/FF; set_i in cycle 6.
3. irq=1 with i_flag=1.
   -> no acceptance.
   Then i_flag=0.
   -> accepted next boundary, kind=2, b_flag=0.
4. nmi 0→1 pulse one cycle wide while busy with IRQ (macro off).
   -> IRQ completes with FE/FF; at next boundary kind=1, vec_adl FA/FB.
   nmi held high afterwards.
   -> no second NMI.
5. nmi rises and brk=1 on the same boundary.
   -> kind=1 (NMI wins).
   With NMI_HIJACK_EN: BRK with nmi edge in cycle 3.
   -> cycle 6 vec_adl=FA; b_flag was 1 in cycle 5.
6. rdy=0 for 3 cycles during cycle 4.
   -> cycle stays 4; all strobes 0; resumes with push_src=1, push_we=1.
   rst pulse in cycle 5.
   -> cycle=0 immediately; next sequence kind=0.
